// File: rtl/divider_inv_pkg.sv
// divider_inv_pkg: shared widths and FSM state type for the divider inverse checker
package divider_inv_pkg;
  localparam int W = 8;
  localparam int NW = 2 * W;
  localparam int IW = $clog2(W);
  localparam int AW = 32;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
endpackage

// File: rtl/divider_array_inverse_check_seq_if.sv
// divider_array_inverse_check_seq_if: operand/result handshake bundle of the inverse checker
interface divider_array_inverse_check_seq_if;
  import divider_inv_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [W-1:0] q;
  logic [W-1:0] d;
  logic [W-1:0] r;
  logic [NW-1:0] n_ref;
  logic out_valid;
  logic out_ready;
  logic [NW-1:0] n_hat;
  logic [NW-1:0] abs_err;
  logic mismatch;
  modport master(output in_valid, q, d, r, n_ref, out_ready, input in_ready, out_valid, n_hat, abs_err, mismatch);
  modport slave(input in_valid, q, d, r, n_ref, out_ready, output in_ready, out_valid, n_hat, abs_err, mismatch);
endinterface

// File: rtl/divider_inv_absdiff.sv
// divider_inv_absdiff: combinational unsigned |a-b| over NW bits
module divider_inv_absdiff
  import divider_inv_pkg::*;
(
  input  logic [NW-1:0] a_i,
  input  logic [NW-1:0] b_i,
  output logic [NW-1:0] y_o
);
  assign y_o = (a_i >= b_i) ? a_i - b_i : b_i - a_i;
endmodule

// File: rtl/divider_array_inverse_check_seq.sv
// divider_array_inverse_check_seq: rebuilds n_hat=q*d+r by shift-add and reports |n_ref-n_hat|; DIV_INV_ERR_ACCUM_EN adds error statistics
module divider_array_inverse_check_seq
  import divider_inv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  divider_array_inverse_check_seq_if.slave bus
`ifdef DIV_INV_ERR_ACCUM_EN
  ,
  input  logic err_clr,
  output logic [AW-1:0] err_sum,
  output logic [NW-1:0] err_max,
  output logic [AW-1:0] sample_cnt
`endif
);
  state_t state_q;
  logic [IW-1:0] i_q;
  logic [W-1:0] q_q;
  logic [NW-1:0] acc_q, acc_d, mcand_q, nref_q, n_hat_q, abs_err_q, diff;
  logic mismatch_q, out_valid_q, in_ready_q;
  assign acc_d = q_q[i_q] ? acc_q + (mcand_q << i_q) : acc_q;
  divider_inv_absdiff u_diff (.a_i(nref_q), .b_i(acc_q), .y_o(diff));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q <= '0;
      q_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      nref_q <= '0;
      n_hat_q <= '0;
      abs_err_q <= '0;
      mismatch_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            q_q <= bus.q;
            acc_q <= NW'(bus.r);
            mcand_q <= NW'(bus.d);
            nref_q <= bus.n_ref;
            i_q <= '0;
            in_ready_q <= 1'b0;
            state_q <= MUL;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        MUL: begin
          acc_q <= acc_d;
          i_q <= i_q + 1'b1;
          if (i_q == IW'(W - 1)) state_q <= DONE;
        end
        DONE: begin
          // first DONE cycle captures the final sum; later cycles hold it until accepted
          if (!out_valid_q) begin
            n_hat_q <= acc_q;
            abs_err_q <= diff;
            mismatch_q <= |diff;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.n_hat = n_hat_q;
  assign bus.abs_err = abs_err_q;
  assign bus.mismatch = mismatch_q;
`ifdef DIV_INV_ERR_ACCUM_EN
  logic [AW-1:0] sum_q, cnt_q;
  logic [NW-1:0] max_q;
  logic [AW:0] sum_d;
  assign sum_d = {1'b0, sum_q} + (AW + 1)'(abs_err_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst || err_clr) begin
      sum_q <= '0;
      max_q <= '0;
      cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      sum_q <= sum_d[AW] ? '1 : sum_d[AW-1:0];
      max_q <= (abs_err_q > max_q) ? abs_err_q : max_q;
      cnt_q <= &cnt_q ? cnt_q : cnt_q + 1'b1;
    end
  end
  assign err_sum = sum_q;
  assign err_max = max_q;
  assign sample_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_divider_array_inverse_check_seq.sv
// tb_divider_array_inverse_check_seq: table-driven scoreboard bench for the divider inverse checker
module tb_divider_array_inverse_check_seq;
  import divider_inv_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  divider_array_inverse_check_seq_if bus();
  divider_array_inverse_check_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] q, d, r;
    logic [NW-1:0] n_ref, n_hat, abs_err;
    logic mis;
  } vec_t;
  vec_t sb[$];
  vec_t tbl[8];
  int vectors = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [W-1:0] q, d, r, input logic [NW-1:0] n_ref);
    vec_t v;
    logic [NW-1:0] n;
    n = NW'(q) * NW'(d) + NW'(r);
    v = '{q, d, r, n_ref, n, (n_ref > n) ? n_ref - n : n - n_ref, n_ref != n};
    return v;
  endfunction
  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", NW'(bus.in_ready), NW'(1));
  endtask
  task automatic apply(input vec_t v, input int hold);
    int n;
    logic [NW-1:0] h, e;
    vec_t x;
    bus.q = v.q; bus.d = v.d; bus.r = v.r; bus.n_ref = v.n_ref;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    wait_ready();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb.push_back(v);
    vectors++;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", NW'(n), NW'(W + 1));
    h = bus.n_hat; e = bus.abs_err;
    if (hold > 0) begin
      bus.q = '1; bus.d = '1; bus.r = '1; bus.n_ref = '0; bus.in_valid = 1'b1;
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("bp_n_hat", bus.n_hat, h);
      chk("bp_abs_err", bus.abs_err, e);
      chk("bp_in_ready", NW'(bus.in_ready), NW'(0));
      chk("bp_out_valid", NW'(bus.out_valid), NW'(1));
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_underflow: got empty queue expected entry");
    end else begin
      x = sb.pop_front();
      chk("n_hat", bus.n_hat, x.n_hat);
      chk("abs_err", bus.abs_err, x.abs_err);
      chk("mismatch", NW'(bus.mismatch), NW'(x.mis));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("out_valid_drop", NW'(bus.out_valid), NW'(0));
    chk("in_ready_after", NW'(bus.in_ready), NW'(1));
  endtask
  initial begin
    int seen;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.q = '0; bus.d = '0; bus.r = '0; bus.n_ref = '0;
    tbl[0] = '{8'h0F, 8'h11, 8'h03, 16'h0102, 16'h0102, 16'h0000, 1'b0};
    tbl[1] = '{8'h0F, 8'h11, 8'h03, 16'h0100, 16'h0102, 16'h0002, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 16'hFF00, 16'hFF00, 16'h0000, 1'b0};
    tbl[3] = '{8'hAB, 8'h00, 8'h05, 16'h0010, 16'h0005, 16'h000B, 1'b1};
    tbl[4] = '{8'h12, 8'h34, 8'h05, 16'h0400, 16'h03AD, 16'h0053, 1'b1};
    tbl[5] = '{8'h80, 8'h02, 8'h01, 16'h0200, 16'h0101, 16'h00FF, 1'b1};
    tbl[6] = '{8'hFF, 8'hFF, 8'hFF, 16'h0000, 16'hFF00, 16'hFF00, 1'b1};
    tbl[7] = '{8'h01, 8'h01, 8'h00, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", NW'(bus.in_ready), NW'(0));
    chk("rst_out_valid", NW'(bus.out_valid), NW'(0));
    chk("rst_n_hat", bus.n_hat, NW'(0));
    chk("rst_abs_err", bus.abs_err, NW'(0));
    chk("rst_mismatch", NW'(bus.mismatch), NW'(0));
    rst = 1'b0;
    for (int i = 0; i < 8; i++) apply(tbl[i], (i == 1) ? 5 : 0);
    for (int i = 0; i < 4; i++)
      apply(mk(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
               NW'($urandom_range(0, 65535))), i);
    bus.q = 8'h0F; bus.d = 8'h11; bus.r = 8'h03; bus.n_ref = 16'h0000; bus.in_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", NW'(bus.out_valid), NW'(0));
    chk("abort_n_hat", bus.n_hat, NW'(0));
    chk("abort_abs_err", bus.abs_err, NW'(0));
    chk("abort_mismatch", NW'(bus.mismatch), NW'(0));
    chk("abort_in_ready", NW'(bus.in_ready), NW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("abort_no_output", NW'(seen), NW'(0));
    apply(tbl[0], 0);
    apply(tbl[3], 2);
    chk("sb_empty", NW'(sb.size()), NW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
